clkrst_ctrl: RTL and testbench

Clock-enable and reset sequencer sitting directly downstream of the `pll` wrapper. It watches the lock flags of the three PLLs and holds the system in reset until every PLL has been stably locked for a programmable time. It then produces a CPU clock enable and a square CPU clock at one of four selectable speeds, with glitch-free, period-aligned speed switching. It runs entirely on the master clock taken from `pll_0_outclk1_clk`.

---
 rtl/clkrst_ctrl.sv | 178 +++++++++++++++++
 tb/tb_clkrst_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkrst_ctrl.sv
// Reset sequencer and CPU clock-enable generator behind the PLL wrapper.
// Holds sys_reset until all PLLs stay locked for LOCK_HOLD cycles, then runs a switchable divider.
module clkrst_ctrl #(
    parameter int NUM_PLL       = 3,
    parameter int LOCK_HOLD     = 1024,
    parameter int HOLD_W        = 11,
    parameter int DIV_W         = 8,
    parameter int DIV_0         = 56,
    parameter int DIV_1         = 28,
    parameter int DIV_2         = 14,
    parameter int DIV_3         = 7,
    parameter int DEFAULT_SPEED = 0
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [NUM_PLL-1:0] pll_locked,
    input  logic [1:0]         speed_sel,
    input  logic               speed_req,
    output logic [1:0]         speed_cur,
    output logic               speed_busy,
    output logic               cpu_clken,
    output logic               cpu_clk,
    output logic               locked_all,
    output logic               sys_reset
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    function automatic logic [DIV_W-1:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    div_of = DIV_W'(DIV_0);
            2'd1:    div_of = DIV_W'(DIV_1);
            2'd2:    div_of = DIV_W'(DIV_2);
            2'd3:    div_of = DIV_W'(DIV_3);
            default: div_of = DIV_W'(DIV_0);
        endcase
    endfunction

    logic [NUM_PLL-1:0] sync1_q, sync2_q;
    logic [1:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         speed_cur_q, speed_cur_d;
    logic [1:0]         speed_new_q, speed_new_d;
    logic               busy_q, busy_d;
    logic               clken_q, clken_d;
    logic               clk_q, clk_d;
    logic [DIV_W-1:0]   div_cur_s, div_nxt_s, cnt_inc_s;
    logic               cnt_wrap_s, run_nxt_s;

    // Next-state logic for the sequencer FSM, hold counter and divider.
    always_comb begin
        state_d     = state_q;
        hold_d      = {HOLD_W{1'b0}};
        cnt_d       = cnt_q;
        speed_cur_d = speed_cur_q;
        speed_new_d = speed_new_q;
        busy_d      = busy_q;
        div_cur_s   = div_of(speed_cur_q);
        cnt_wrap_s  = (cnt_q == (div_cur_s - DIV_W'(1)));
        cnt_inc_s   = cnt_wrap_s ? {DIV_W{1'b0}} : (cnt_q + DIV_W'(1));

        case (state_q)
            ST_WAIT: begin
                cnt_d = {DIV_W{1'b0}};
                if (speed_req) begin
                    speed_cur_d = speed_sel;
                end else begin
                    speed_cur_d = speed_cur_q;
                end
                if (locked_all) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // Speed changes before release take effect at once, restarting the period.
                if (speed_req) begin
                    speed_cur_d = speed_sel;
                end else begin
                    speed_cur_d = speed_cur_q;
                end
                if (!locked_all) begin
                    state_d = ST_WAIT;
                    cnt_d   = {DIV_W{1'b0}};
                end else begin
                    cnt_d = speed_req ? {DIV_W{1'b0}} : cnt_inc_s;
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (!locked_all) begin
                    state_d = ST_WAIT;
                    cnt_d   = {DIV_W{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                    if (speed_req) begin
                        speed_new_d = speed_sel;
                        busy_d      = 1'b1;
                        state_d     = ST_SWITCH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_SWITCH: begin
                // The new divisor is loaded only at a period boundary so no phase is truncated.
                if (!locked_all) begin
                    state_d = ST_WAIT;
                    cnt_d   = {DIV_W{1'b0}};
                    busy_d  = 1'b0;
                end else if (cnt_wrap_s) begin
                    state_d     = ST_RUN;
                    cnt_d       = {DIV_W{1'b0}};
                    speed_cur_d = speed_new_q;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = {DIV_W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase

        run_nxt_s = (state_d != ST_WAIT);
        div_nxt_s = div_of(speed_cur_d);
        clken_d   = run_nxt_s && (cnt_d == (div_nxt_s - DIV_W'(1)));
        clk_d     = run_nxt_s && (cnt_d < (div_nxt_s >> 1));
    end

    // State registers, lock synchronisers and registered clock outputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q     <= {NUM_PLL{1'b0}};
            sync2_q     <= {NUM_PLL{1'b0}};
            state_q     <= ST_WAIT;
            hold_q      <= {HOLD_W{1'b0}};
            cnt_q       <= {DIV_W{1'b0}};
            speed_cur_q <= 2'(DEFAULT_SPEED);
            speed_new_q <= 2'(DEFAULT_SPEED);
            busy_q      <= 1'b0;
            clken_q     <= 1'b0;
            clk_q       <= 1'b0;
        end else begin
            sync1_q     <= pll_locked;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            speed_cur_q <= speed_cur_d;
            speed_new_q <= speed_new_d;
            busy_q      <= busy_d;
            clken_q     <= clken_d;
            clk_q       <= clk_d;
        end
    end

    assign locked_all = &sync2_q;
    assign sys_reset  = (state_q != ST_RUN) && (state_q != ST_SWITCH);
    assign speed_cur  = speed_cur_q;
    assign speed_busy = busy_q;
    assign cpu_clken  = clken_q;
    assign cpu_clk    = clk_q;

endmodule

// File: tb/tb_clkrst_ctrl.sv
// Bench for clkrst_ctrl: directed scenarios plus random requests/glitches,
// every cycle compared against a phase-based reference model.
module tb_clkrst_ctrl;

    localparam int LOCK_HOLD = 1024;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [2:0] pll_locked;
    logic [1:0] speed_sel;
    logic       speed_req;
    logic [1:0] speed_cur;
    logic       speed_busy, cpu_clken, cpu_clk, locked_all, sys_reset;

    clkrst_ctrl dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .pll_locked (pll_locked),
        .speed_sel  (speed_sel),
        .speed_req  (speed_req),
        .speed_cur  (speed_cur),
        .speed_busy (speed_busy),
        .cpu_clken  (cpu_clken),
        .cpu_clk    (cpu_clk),
        .locked_all (locked_all),
        .sys_reset  (sys_reset)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: mode 0 waiting for lock, 1 counting lock time, 2 released.
    int       divs [4] = '{56, 28, 14, 7};
    bit [2:0] m_s1 = 3'b0, m_s2 = 3'b0;
    int       m_mode = 0, m_hold = 0, m_phase = 0, m_speed = 0, m_pend = -1;

    task automatic model_edge();
        bit la;
        int d;
        if (reset_reset) begin
            m_s1 = 3'b0; m_s2 = 3'b0;
            m_mode = 0; m_hold = 0; m_phase = 0; m_speed = 0; m_pend = -1;
        end else begin
            la   = &m_s2;
            m_s2 = m_s1;
            m_s1 = pll_locked;
            d    = divs[m_speed];
            if (m_mode == 0) begin
                m_phase = 0;
                if (speed_req) m_speed = int'(speed_sel);
                if (la) begin m_mode = 1; m_hold = 0; end
            end else if (m_mode == 1) begin
                if (speed_req) m_speed = int'(speed_sel);
                if (!la) begin
                    m_mode = 0; m_phase = 0;
                end else begin
                    m_phase = speed_req ? 0 : (m_phase + 1) % d;
                    if (m_hold == LOCK_HOLD - 1) m_mode = 2;
                    else m_hold++;
                end
            end else begin
                if (!la) begin
                    m_mode = 0; m_phase = 0; m_pend = -1;
                end else if (m_pend < 0) begin
                    m_phase = (m_phase + 1) % d;
                    if (speed_req) m_pend = int'(speed_sel);
                end else if (m_phase == d - 1) begin
                    m_phase = 0; m_speed = m_pend; m_pend = -1;
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    function automatic logic [31:0] model_outs();
        bit run;
        int d;
        run = (m_mode != 0);
        d   = divs[m_speed];
        return {25'd0, (m_mode != 2), (&m_s2), (m_pend >= 0), 2'(m_speed),
                (run && m_phase < d / 2), (run && m_phase == d - 1)};
    endfunction

    task automatic step();
        @(posedge clk_clk);
        model_edge();
        #1;
        cyc++;
        check_eq("outs", {25'd0, sys_reset, locked_all, speed_busy, speed_cur, cpu_clk, cpu_clken},
                 model_outs());
    endtask

    task automatic wait_clken(input int max_cyc, output int t);
        t = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (cpu_clken) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check_eq("clken_timeout", {31'd0, cpu_clken}, 32'd1);
    endtask

    int lock_edge, drop_edge, fall_cyc, t0, t1, t_prev, t_a, t_b, busy_n, hi_n;

    initial begin
        reset_reset = 1'b1;
        pll_locked  = 3'b000;
        speed_sel   = 2'd0;
        speed_req   = 1'b0;
        repeat (3) step();
        reset_reset = 1'b0;
        check_eq("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
        check_eq("rst_speed_cur", {30'd0, speed_cur}, 32'd0);
        repeat (10) step();

        // Lock all PLLs; locked_all rises one edge after the sampling edge.
        pll_locked = 3'b111;
        step();
        lock_edge = cyc;
        check_eq("la_early", {31'd0, locked_all}, 32'd0);
        step();
        check_eq("la_rise", {31'd0, locked_all}, 32'd1);

        // Speed request during HOLD applies immediately with a 28-cycle period.
        repeat (40) step();
        speed_sel = 2'd1; speed_req = 1'b1;
        step();
        speed_req = 1'b0;
        check_eq("hold_req_speed", {30'd0, speed_cur}, 32'd1);
        check_eq("hold_req_busy", {31'd0, speed_busy}, 32'd0);
        wait_clken(100, t0);
        wait_clken(100, t1);
        check_eq("hold_period", 32'(t1 - t0), 32'd28);

        // One-cycle glitch on lock bit 1 at hold count 500.
        while (cyc < lock_edge + 2 + 500) step();
        pll_locked = 3'b101;
        step();
        drop_edge  = cyc;
        pll_locked = 3'b111;
        fall_cyc   = -1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!sys_reset) begin fall_cyc = cyc; break; end
        end
        check_eq("release_time", 32'(fall_cyc), 32'(drop_edge + 1 + 2 + LOCK_HOLD));

        // Switch to speed 0 so the 0 -> 3 scenario can start from a 56-cycle period.
        speed_sel = 2'd0; speed_req = 1'b1;
        step();
        speed_req = 1'b0;
        for (int i = 0; i < 100 && speed_busy; i++) step();
        check_eq("sw0_speed", {30'd0, speed_cur}, 32'd0);

        // Request 0 -> 3 when cnt=20; busy until the edge where cnt=55, i.e. 35 cycles.
        wait_clken(200, t_prev);
        repeat (21) step();
        speed_sel = 2'd3; speed_req = 1'b1;
        step();
        speed_req = 1'b0;
        busy_n = 0;
        t_a = -1;
        check_eq("sw3_busy", {31'd0, speed_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (speed_busy) busy_n++;
            step();
        end
        speed_sel = 2'd2; speed_req = 1'b1;
        for (int i = 0; i < 100 && speed_busy; i++) begin
            busy_n++;
            if (cpu_clken) t_a = cyc;
            step();
            speed_req = 1'b0;
        end
        check_eq("sw3_busy_len", 32'(busy_n), 32'(56 - 1 - 20));
        check_eq("sw3_old_period", 32'(t_a - t_prev), 32'd56);
        hi_n = 0;
        t_b  = -1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            if (cpu_clk) hi_n++;
            if (cpu_clken) t_b = cyc;
        end
        check_eq("sw3_new_period", 32'(t_b - t_a), 32'd7);
        check_eq("sw3_clk_high", 32'(hi_n), 32'd3);
        check_eq("sw3_ignored_req", {30'd0, speed_cur}, 32'd3);

        // Reset while a switch is pending.
        speed_sel = 2'd1; speed_req = 1'b1;
        step();
        speed_req = 1'b0;
        check_eq("mid_busy", {31'd0, speed_busy}, 32'd1);
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
        check_eq("mid_sys_reset", {31'd0, sys_reset}, 32'd1);
        check_eq("mid_busy_clr", {31'd0, speed_busy}, 32'd0);
        check_eq("mid_speed", {30'd0, speed_cur}, 32'd0);
        check_eq("mid_clk", {31'd0, cpu_clk}, 32'd0);

        // Random requests, lock glitches and occasional resets, checked by the model.
        for (int i = 0; i < 5000; i++) begin
            speed_sel   = 2'($urandom_range(0, 3));
            speed_req   = ($urandom_range(0, 29) == 0);
            reset_reset = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 1499) == 0) pll_locked = 3'b111 & ~(3'b001 << $urandom_range(0, 2));
            else pll_locked = 3'b111;
            step();
        end
        speed_req   = 1'b0;
        reset_reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
